// File: rtl/regfile_cc_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_cc_if : write/read/CC/BEN/soft-clear bundle for the GPR file |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface regfile_cc_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    logic              LD_REG;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic              LD_CC;
    logic [DATA_W-1:0] cc_data;
    logic              N;
    logic              Z;
    logic              P;
    logic              LD_BEN;
    logic [2:0]        ir_nzp;
    logic              BEN;
    logic              clr_req;
    logic              busy;
    logic              clr_done;

    modport master (
        output LD_REG, wr_addr, wr_data, rd_addr_a, rd_addr_b,
        output LD_CC, cc_data, LD_BEN, ir_nzp, clr_req,
        input  rd_data_a, rd_data_b, N, Z, P, BEN, busy, clr_done
    );

    modport slave (
        input  LD_REG, wr_addr, wr_data, rd_addr_a, rd_addr_b,
        input  LD_CC, cc_data, LD_BEN, ir_nzp, clr_req,
        output rd_data_a, rd_data_b, N, Z, P, BEN, busy, clr_done
    );
endinterface
`default_nettype wire

// File: rtl/regfile_cc_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_cc_unit : GPR file + NZP + BEN with soft-clear sequencer      |
// | Option macro: REGFILE_BYPASS_EN (write-through read)  Rev 1.0        |
// +----------------------------------------------------------------------+
module regfile_cc_unit #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8
) (
    input  wire          Clk,
    input  wire          Reset_n,
    regfile_cc_if.slave  rf
);
    localparam int ADDR_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state, state_d;
    logic [ADDR_W-1:0] cnt, cnt_d;
    logic              clr_en;
    logic              clr_start;
    logic              busy;
    logic              wr_en;
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [2:0]        nzp;
    logic              ben;
    logic [DATA_W-1:0] rd_a, rd_b;

    assign busy  = (state == CLEAR);
    assign wr_en = rf.LD_REG && !busy;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        clr_en    = 1'b0;
        clr_start = 1'b0;
        case (state)
            IDLE: begin
                if (rf.clr_req) begin
                    state_d   = CLEAR;
                    cnt_d     = '0;
                    clr_start = 1'b1;
                end
            end
            CLEAR: begin
                clr_en = 1'b1;
                if (cnt == LAST_IDX) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + ADDR_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Indices >= NUM_REGS never match any slot, so such writes fall away.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (clr_en && cnt == ADDR_W'(i))
                    regs[i] <= '0;
                else if (wr_en && rf.wr_addr == ADDR_W'(i))
                    regs[i] <= rf.wr_data;
            end
        end
    end

    always_comb begin
        rd_a = '0;
        rd_b = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rf.rd_addr_a == ADDR_W'(i)) rd_a = regs[i];
            if (rf.rd_addr_b == ADDR_W'(i)) rd_b = regs[i];
        end
`ifdef REGFILE_BYPASS_EN
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_en && rf.wr_addr == ADDR_W'(i)) begin
                if (rf.rd_addr_a == ADDR_W'(i)) rd_a = rf.wr_data;
                if (rf.rd_addr_b == ADDR_W'(i)) rd_b = rf.wr_data;
            end
        end
`endif
    end

    // BEN samples the pre-edge NZP, so a same-edge LD_CC is not seen.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            nzp <= 3'b010;
            ben <= 1'b0;
        end else begin
            if (clr_start)
                nzp <= 3'b010;
            else if (rf.LD_CC && !busy)
                nzp <= {rf.cc_data[DATA_W-1], (rf.cc_data == '0),
                        !rf.cc_data[DATA_W-1] && (rf.cc_data != '0)};
            if (rf.LD_BEN)
                ben <= |(rf.ir_nzp & nzp);
        end
    end

    assign rf.rd_data_a = rd_a;
    assign rf.rd_data_b = rd_b;
    assign rf.N         = nzp[2];
    assign rf.Z         = nzp[1];
    assign rf.P         = nzp[0];
    assign rf.BEN       = ben;
    assign rf.busy      = busy;
    assign rf.clr_done  = (state == DONE);
endmodule
`default_nettype wire

// File: tb/tb_regfile_cc_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_regfile_cc_unit : directed scoreboard bench for regfile_cc_unit    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_regfile_cc_unit;
    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    always #5 Clk = ~Clk;

    regfile_cc_if #(.DATA_W(16), .ADDR_W(3)) rf ();
    regfile_cc_if #(.DATA_W(16), .ADDR_W(3)) rf2 ();

    regfile_cc_unit #(.DATA_W(16), .NUM_REGS(8)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .rf(rf)
    );
    // Second instance with a non power-of-two depth exposes out-of-range indices.
    regfile_cc_unit #(.DATA_W(16), .NUM_REGS(5)) dut5 (
        .Clk(Clk), .Reset_n(Reset_n), .rf(rf2)
    );

    typedef struct {
        int          kind;
        logic [15:0] val;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass = 0;
    int   n_total = 0;

    function automatic logic [15:0] pick(input int k);
        case (k)
            0:       return rf.rd_data_a;
            1:       return rf.rd_data_b;
            2:       return {13'b0, rf.N, rf.Z, rf.P};
            3:       return {15'b0, rf.BEN};
            4:       return {15'b0, rf.busy};
            5:       return {15'b0, rf.clr_done};
            6:       return rf2.rd_data_a;
            default: return 16'hxxxx;
        endcase
    endfunction

    exp_t        e;
    logic [15:0] act;
    always @(negedge Clk) begin
        while (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = pick(e.kind);
            n_total++;
            if (act === e.val) n_pass++;
            else $display("FAIL %s: got %h, want %h", e.name, act, e.val);
        end
    end

    task automatic chk(input int k, input logic [15:0] v, input string nm);
        exp_q.push_back('{k, v, nm});
    endtask

    task automatic next();
        @(posedge Clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] ad, input logic [15:0] d);
        rf.LD_REG = 1'b1; rf.wr_addr = ad; rf.wr_data = d;
        next();
        rf.LD_REG = 1'b0;
    endtask

    task automatic ldcc(input logic [15:0] d);
        rf.LD_CC = 1'b1; rf.cc_data = d;
        next();
        rf.LD_CC = 1'b0;
    endtask

    task automatic ldben(input logic [2:0] m);
        rf.LD_BEN = 1'b1; rf.ir_nzp = m;
        next();
        rf.LD_BEN = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rf.LD_REG = 0; rf.wr_addr = 0; rf.wr_data = 0; rf.rd_addr_a = 0; rf.rd_addr_b = 0;
        rf.LD_CC = 0; rf.cc_data = 0; rf.LD_BEN = 0; rf.ir_nzp = 0; rf.clr_req = 0;
        rf2.LD_REG = 0; rf2.wr_addr = 0; rf2.wr_data = 0; rf2.rd_addr_a = 0; rf2.rd_addr_b = 0;
        rf2.LD_CC = 0; rf2.cc_data = 0; rf2.LD_BEN = 0; rf2.ir_nzp = 0; rf2.clr_req = 0;
        next();

        // 1. reset state
        for (int i = 0; i < 8; i++) begin
            rf.rd_addr_a = 3'(i); rf.rd_addr_b = 3'(7 - i);
            chk(0, 16'h0, "reset_rd_a"); chk(1, 16'h0, "reset_rd_b");
            next();
        end
        chk(2, 16'h0002, "reset_nzp"); chk(3, 16'h0, "reset_ben");
        chk(4, 16'h0, "reset_busy"); chk(5, 16'h0, "reset_done");
        next();
        Reset_n = 1'b1;
        next();

        // 2. write + condition codes
        wr(3'd3, 16'h8001);
        rf.rd_addr_a = 3'd3; chk(0, 16'h8001, "r3_read");
        ldcc(16'h8001); chk(2, 16'h0004, "cc_neg");
        ldcc(16'h0000); chk(2, 16'h0002, "cc_zero");
        ldcc(16'h7FFF); chk(2, 16'h0001, "cc_pos");

        // 3. BEN
        ldcc(16'h8001);
        ldben(3'b100); chk(3, 16'h1, "ben_n_hit");
        ldben(3'b011); chk(3, 16'h0, "ben_n_miss");
        ldben(3'b100); chk(3, 16'h1, "ben_set_again");
        rf.LD_CC = 1'b1; rf.cc_data = 16'h0000; rf.LD_BEN = 1'b1; rf.ir_nzp = 3'b010;
        next();
        rf.LD_CC = 1'b0; rf.LD_BEN = 1'b0;
        chk(3, 16'h0, "ben_same_edge_old_n"); chk(2, 16'h0002, "cc_same_edge_z");
        rf.LD_CC = 1'b1; rf.cc_data = 16'h8001; rf.LD_BEN = 1'b1; rf.ir_nzp = 3'b010;
        next();
        rf.LD_CC = 1'b0; rf.LD_BEN = 1'b0;
        chk(3, 16'h1, "ben_same_edge_old_z");

        // 4. soft clear
        for (int i = 0; i < 8; i++) wr(3'(i), 16'(16'h1111 * i));
        ldcc(16'h8001);
        rf.clr_req = 1'b1;
        next();
        for (int k = 1; k <= 8; k++) begin
            rf.LD_REG = 1'b1; rf.wr_addr = 3'd7; rf.wr_data = 16'hFFFF;
            rf.LD_CC = 1'b1; rf.cc_data = 16'h8001;
            rf.rd_addr_a = 3'(k - 1);
            rf.rd_addr_b = (k == 1) ? 3'd7 : 3'(k - 2);
            chk(4, 16'h1, "clr_busy"); chk(5, 16'h0, "clr_done_early");
            chk(2, 16'h0002, "clr_cc_z");
            chk(0, 16'(16'h1111 * (k - 1)), "clr_live_uncleared");
            chk(1, (k == 1) ? 16'h7777 : 16'h0000, "clr_live_cleared");
            next();
        end
        rf.LD_REG = 1'b0; rf.LD_CC = 1'b0;
        chk(4, 16'h0, "clr_busy_end"); chk(5, 16'h1, "clr_done_pulse");
        next();
        rf.clr_req = 1'b0;
        chk(4, 16'h0, "clr_no_restart"); chk(5, 16'h0, "clr_done_once");
        next();
        for (int i = 0; i < 8; i++) begin
            rf.rd_addr_a = 3'(i);
            chk(0, 16'h0, "clr_all_zero");
            next();
        end
        chk(2, 16'h0002, "clr_cc_final");

        // 5. reset mid-clear
        wr(3'd6, 16'h5678);
        ldben(3'b010); chk(3, 16'h1, "pre_reset_ben");
        rf.clr_req = 1'b1;
        next();
        rf.clr_req = 1'b0;
        chk(4, 16'h1, "midclr_busy");
        next();
        next();
        Reset_n = 1'b0;
        rf.rd_addr_a = 3'd6;
        chk(0, 16'h0, "async_rst_r6"); chk(4, 16'h0, "async_rst_busy");
        chk(3, 16'h0, "async_rst_ben"); chk(5, 16'h0, "async_rst_done");
        next();
        Reset_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            chk(5, 16'h0, "abandoned_no_done"); chk(4, 16'h0, "abandoned_idle");
            next();
        end

        // 6. write-through
        rf.LD_REG = 1'b1; rf.wr_addr = 3'd5; rf.wr_data = 16'hABCD; rf.rd_addr_a = 3'd5;
`ifdef REGFILE_BYPASS_EN
        chk(0, 16'hABCD, "bypass_same_cycle");
`else
        chk(0, 16'h0000, "no_bypass_same_cycle");
`endif
        next();
        rf.LD_REG = 1'b0;
        chk(0, 16'hABCD, "r5_after_edge");

        // out-of-range indices on the 5-deep instance
        rf2.LD_REG = 1'b1; rf2.wr_addr = 3'd4; rf2.wr_data = 16'h4444;
        next();
        rf2.wr_addr = 3'd6; rf2.wr_data = 16'h6666; rf2.rd_addr_a = 3'd6;
        chk(6, 16'h0, "oor_bypass_none");
        next();
        rf2.LD_REG = 1'b0;
        chk(6, 16'h0, "oor_read_6");
        next();
        rf2.rd_addr_a = 3'd4; chk(6, 16'h4444, "r4_in_range");
        next();
        rf2.rd_addr_a = 3'd2; chk(6, 16'h0, "oor_no_alias");
        next();
        rf2.rd_addr_a = 3'd5; chk(6, 16'h0, "oor_read_5");
        next();

        for (int k = 0; k < 4 && exp_q.size() > 0; k++) next();
        if (exp_q.size() > 0) begin
            n_total++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
